// File: rtl/config_pkg.sv
// Shared constants and state encoding for the fabric configuration bus.
// Address layout: [15:0] tile id, [31:16] module id.
package config_pkg;

    localparam int CONFIG_ADDR_W = 32;
    localparam int CONFIG_DATA_W = 32;

    localparam int TILE_ID_LSB = 0;
    localparam int TILE_ID_MSB = 15;
    localparam int MOD_ID_LSB  = 16;
    localparam int MOD_ID_MSB  = 31;

    localparam logic [CONFIG_ADDR_W-1:0] DEFAULT_IDLE_ADDR = 32'hFFFF_FFFF;
    localparam logic [CONFIG_ADDR_W-1:0] DEFAULT_END_ADDR  = 32'hFFFF_FFFE;

    typedef enum logic [2:0] {
        WAIT_ADDR = 3'd0,
        WAIT_DATA = 3'd1,
        WRITE     = 3'd2,
        GAP       = 3'd3,
        DONE      = 3'd4
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/config_loader.sv
// Configuration master: consumes {address, data} word pairs and drives each
// write onto the shared config bus for HOLD_CYCLES cycles, then one idle cycle.
module config_loader
    import config_pkg::*;
#(
    parameter int unsigned                     HOLD_CYCLES = 2,
    parameter logic [CONFIG_ADDR_W-1:0]        IDLE_ADDR   = DEFAULT_IDLE_ADDR,
    parameter logic [CONFIG_ADDR_W-1:0]        END_ADDR    = DEFAULT_END_ADDR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_word,
    output logic [CONFIG_ADDR_W-1:0] config_addr,
    output logic [CONFIG_DATA_W-1:0] config_data,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              write_count
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready is a pure function of state and never looks at in_valid.

    state_t                     state_q, state_d;
    logic [CONFIG_ADDR_W-1:0]   addr_q, addr_d;
    logic [CONFIG_ADDR_W-1:0]   config_addr_q, config_addr_d;
    logic [CONFIG_DATA_W-1:0]   config_data_q, config_data_d;
    logic [3:0]                 hold_cnt_q, hold_cnt_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [15:0]                write_count_q, write_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_ADDR;
            addr_q        <= '0;
            config_addr_q <= IDLE_ADDR;
            config_data_q <= '0;
            hold_cnt_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            config_addr_q <= config_addr_d;
            config_data_q <= config_data_d;
            hold_cnt_q    <= hold_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            write_count_q <= write_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        config_addr_d = config_addr_q;
        config_data_d = config_data_q;
        hold_cnt_d    = hold_cnt_q;
        busy_d        = busy_q;
        done_d        = done_q;
        write_count_d = write_count_q;
        in_ready      = 1'b0;

        unique case (state_q)
            WAIT_ADDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    addr_d = in_word;
                    if (in_word == END_ADDR) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_DATA;
                        busy_d  = 1'b1;
                    end
                end
            end
            WAIT_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    config_addr_d = addr_q;
                    config_data_d = in_word;
                    hold_cnt_d    = 4'(HOLD_CYCLES - 1);
                    state_d       = WRITE;
                end
            end
            WRITE: begin
                if (hold_cnt_q == 4'd0) begin
                    // The bus goes idle on the same edge the write is counted.
                    config_addr_d = IDLE_ADDR;
                    config_data_d = '0;
                    write_count_d = sat_inc16(write_count_q);
                    state_d       = GAP;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            GAP: begin
                busy_d  = 1'b0;
                state_d = WAIT_ADDR;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT_ADDR;
            end
        endcase
    end

    assign config_addr = config_addr_q;
    assign config_data = config_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign write_count = write_count_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: directed scenarios plus a bus monitor that pops
// expected {addr, data, hold length} entries as each write leaves the bus.
module tb_config_loader;

    localparam int unsigned HOLD = 2;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
    localparam logic [31:0] ENDW = 32'hFFFF_FFFE;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic [15:0] write_count;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // entry = {addr[31:0], data[31:0], hold_len[3:0]}
    logic [67:0] exp_q[$];

    config_loader #(
        .HOLD_CYCLES (HOLD),
        .IDLE_ADDR   (IDLE),
        .END_ADDR    (ENDW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .config_addr (config_addr),
        .config_data (config_data),
        .busy        (busy),
        .done        (done),
        .write_count (write_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // driver tasks: called at a negedge, return at the negedge after the transfer
    task automatic send_word(input logic [31:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_word  = w;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d, 4'(HOLD)});
        send_word(a);
        send_word(d);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready && !busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, "_addr"}, config_addr, IDLE);
        check({tag, "_data"}, config_data, 32'd0);
    endtask

    // scoreboard monitor: a write is a run of identical non-idle bus cycles
    logic [63:0] run_val = '0;
    int          run_len = 0;
    always @(negedge clk) begin
        logic [63:0] cur;
        logic [67:0] e;
        logic        active;
        if (mon_en) begin
            cur    = {config_addr, config_data};
            active = (config_addr !== IDLE) || (config_data !== 32'd0);
            if (run_len > 0 && cur !== run_val) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", run_val[63:32], e[67:36]);
                    check("wr_data", run_val[31:0], e[35:4]);
                    check("wr_len", 32'(run_len), 32'(e[3:0]));
                end
                if (active) check("wr_no_gap", 32'd0, 32'd1);
                run_len = 0;
            end
            if (active) begin
                if (run_len == 0) run_val = cur;
                run_len++;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_word  = '0;

        // 1: reset state
        do_reset();
        mon_en = 1'b1;
        check_bus_idle("rst");
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wc", 32'(write_count), 32'd0);

        // 2: single pair, cycle-by-cycle
        exp_q.push_back({32'h0011_0003, 32'h0000_0005, 4'(HOLD)});
        send_word(32'h0011_0003);
        check("t2_busy_wd", 32'(busy), 32'd1);
        check_bus_idle("t2_wd");
        send_word(32'h0000_0005);
        in_valid = 1'b0;
        for (int c = 0; c < int'(HOLD); c++) begin
            check("t2_addr", config_addr, 32'h0011_0003);
            check("t2_data", config_data, 32'h0000_0005);
            check("t2_ready_wr", 32'(in_ready), 32'd0);
            check("t2_busy_wr", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check_bus_idle("t2_gap");
        check("t2_ready_gap", 32'(in_ready), 32'd0);
        check("t2_wc_gap", 32'(write_count), 32'd1);
        @(negedge clk);
        check("t2_ready_after", 32'(in_ready), 32'd1);
        check("t2_busy_after", 32'(busy), 32'd0);
        check("t2_wc", 32'(write_count), 32'd1);

        // 3: three back-to-back pairs then END, in_valid held high
        do_reset();
        send_pair(32'h0001_0001, 32'hA5A5_0001);
        send_pair(32'h0002_0002, 32'hA5A5_0002);
        send_pair(32'h0003_0003, 32'hA5A5_0003);
        send_word(ENDW);
        for (int c = 0; c < 6; c++) begin
            in_word = $urandom;
            check("t3_done", 32'(done), 32'd1);
            check("t3_ready", 32'(in_ready), 32'd0);
            check("t3_wc", 32'(write_count), 32'd3);
            check_bus_idle("t3_bus");
            @(negedge clk);
        end
        in_valid = 1'b0;

        // 4: stall between address and data
        do_reset();
        exp_q.push_back({32'h0010_0001, 32'h0000_0003, 4'(HOLD)});
        send_word(32'h0010_0001);
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check_bus_idle("t4_stall");
            check("t4_stall_ready", 32'(in_ready), 32'd1);
            check("t4_stall_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        send_word(32'h0000_0003);
        in_valid = 1'b0;
        check("t4_addr", config_addr, 32'h0010_0001);
        check("t4_data", config_data, 32'h0000_0003);
        wait_idle();
        check("t4_wc", 32'(write_count), 32'd1);

        // 5: reset on the first WRITE cycle abandons the write
        exp_q.push_back({32'h0020_0002, 32'h0000_0BAD, 4'd1});
        send_word(32'h0020_0002);
        send_word(32'h0000_0BAD);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_bus_idle("t5_rst");
        check("t5_ready", 32'(in_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_wc", 32'(write_count), 32'd0);
        send_pair(32'h0020_0002, 32'h0000_0600D);
        in_valid = 1'b0;
        wait_idle();
        check("t5_wc_after", 32'(write_count), 32'd1);

        // boundary: IDLE_ADDR as address, END_ADDR as data
        send_pair(IDLE, 32'h0000_0077);
        send_pair(32'h0030_0004, ENDW);
        in_valid = 1'b0;
        wait_idle();
        check("bnd_done", 32'(done), 32'd0);
        check("bnd_wc", 32'(write_count), 32'd3);

        // random pairs with random valid gaps
        for (int p = 0; p < 6; p++) begin
            a = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom)};
            d = $urandom;
            exp_q.push_back({a, d, 4'(HOLD)});
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(a);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(d);
            in_valid = 1'b0;
        end
        wait_idle();
        check("rnd_wc", 32'(write_count), 32'd9);

        // 6: saturation of write_count
        force dut.write_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.write_count_q;
        @(negedge clk);
        check("sat_preset", 32'(write_count), 32'h0000_FFFE);
        send_pair(32'h0040_0005, 32'h1234_5678);
        in_valid = 1'b0;
        wait_idle();
        check("sat_reach", 32'(write_count), 32'h0000_FFFF);
        send_pair(32'h0050_0006, 32'h8765_4321);
        in_valid = 1'b0;
        wait_idle();
        check("sat_hold", 32'(write_count), 32'h0000_FFFF);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
